pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Match-flow sequencer for the Pong console.
- Owns game state, scores, serve delay and game-over hold. Commands the ball/paddle physics core via run/show/recentre strobes and consumes its point-scored pulses.
- Sits between the player start button and the physics core. Scores and winner feed the score/overlay renderer.

Parameters:
- SERVE_DELAY_CYC, 50_350_000: cycles the ball stays hidden before each serve (2 s at 25.175 MHz).
- OVER_HOLD_CYC, 125_875_000: cycles the game-over screen is held before returning to attract (5 s).
- MAX_SCORE, 11: winning score. Legal range 1..15.
- CNT_W, 27: delay counter width. Must hold max(SERVE_DELAY_CYC, OVER_HOLD_CYC).

Ports:
- clk_0  in  1  25.175 MHz system clock
- rst  in  1  asynchronous, active-high reset
- start_n  in  1  start button, active low, already synchronised
- pt_p1  in  1  one-cycle pulse from physics core: player 1 scored (ball reached right wall)
- pt_p2  in  1  one-cycle pulse: player 2 scored (ball reached left wall)
- pos_reset  out  1  one-cycle strobe: physics core recentres ball and paddles
- ball_run  out  1  ball motion enable
- ball_shown  out  1  ball visible
- serve_dir  out  1  initial ball x-direction (0 = left, 1 = right)
- score_p1  out  4  player 1 score
- score_p2  out  4  player 2 score
- winner  out  2  00 none, 01 player 1, 10 player 2
- game_over  out  1  high while in OVER
- state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst asserts asynchronously and is released synchronously by the source.
  - Every output and register is registered.
- Reset values:
  - State ATTRACT.
  - score_p1/p2 = 0, winner = 00, serve_dir = 0.
  - pos_reset, ball_run, ball_shown, game_over = 0.
  - Counter = 0.
  - Start edge-detect register = 1 (released).
- Start press: a registered falling edge of start_n (previous 1, current 0). A held button never re-triggers.
- States (encoding ATTRACT=0, POINT=1, SERVE=2, RALLY=3, OVER=4):
  - ATTRACT:
    - ball_run = 0, ball_shown = 0. Scores and winner from the last match stay displayed.
    - On start press: scores := 0, winner := 00, serve_dir := 0, next POINT.
    - pt pulses ignored.
  - POINT:
    - Exactly one cycle; pos_reset = 1 only in this state.
    - Counter := 0, next SERVE.
  - SERVE:
    - ball_shown = 0, ball_run = 0.
    - Counter increments each cycle. When counter == SERVE_DELAY_CYC-1, next RALLY, so SERVE lasts exactly SERVE_DELAY_CYC cycles.
    - pt pulses ignored.
  - RALLY:
    - ball_shown = 1, ball_run = 1.
    - pt_p1 has priority. If pt_p1 and pt_p2 arrive in the same cycle, only player 1 scores and pt_p2 is dropped.
    - On pt_p1: score_p1 += 1, serve_dir := 1 (serve toward the conceding player 2).
      - If the new score == MAX_SCORE: winner := 01, counter := 0, next OVER.
      - Otherwise next POINT.
    - On pt_p2: symmetric, with serve_dir := 0 and winner := 10.
  - OVER:
    - game_over = 1, ball_shown = 0, ball_run = 0.
    - Counter increments. When counter == OVER_HOLD_CYC-1, next ATTRACT with winner retained.
    - A start press in OVER restarts immediately exactly as from ATTRACT (scores cleared, next POINT).
    - pt pulses ignored.
- Outputs ball_run/ball_shown/game_over update on the same edge as the state change; they are decoded from next-state and registered.
- Arithmetic:
  - Scores are 4-bit unsigned.
  - An increment never exceeds MAX_SCORE, so no wrap.
  - Counter never exceeds the applicable limit.
- Reset mid-operation (any state, including mid-delay): immediate return to reset values; no pos_reset strobe is generated.
- Illegal state encodings (5–7) go to ATTRACT on the next clock.

Decomposition:
- Package pong_pkg:
  - state encodings
  - CLK_HZ = 25_175_000
  - default MAX_SCORE
  - winner codes
- Sub-module pong_delay_timer:
  - Loadable up-counter with a limit input, clear, enable and a registered done flag.
  - Used for both the SERVE and OVER delays.
- Start edge detector stays inline.

Test Plan (SERVE_DELAY_CYC=10, OVER_HOLD_CYC=20, MAX_SCORE=3):
- Reset release, start_n held 1 for 50 cycles -> state_dbg=0, all outputs 0. Then pulse start_n low -> pos_reset high exactly 1 cycle, ball_run rises exactly 10 cycles after POINT.
- In RALLY, pulse pt_p1 -> score_p1=1, serve_dir=1, one pos_reset pulse, ball_shown low 10 cycles then high. Repeat with pt_p2 -> score_p2=1, serve_dir=0.
- pt_p1 and pt_p2 asserted in the same RALLY cycle -> score_p1=1, score_p2 unchanged. pt pulses during SERVE -> scores unchanged.
- Three pt_p2 rallies -> winner=10, game_over high exactly 20 cycles, then ATTRACT with score_p2=3 retained. Next start -> scores 0, winner 00.
- start_n held low through OVER->ATTRACT -> no restart until released and pressed again. Start press at OVER cycle 5 -> immediate POINT.
- Assert rst mid-SERVE (counter=6) -> all outputs return to reset values asynchronously, no pos_reset strobe, state_dbg=0.

Source files
------------

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pong match-flow sequencer: state encodings,
// system clock rate, default winning score, winner codes and a small score
// helper.
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_POINT   = 3'd1,
        ST_SERVE   = 3'd2,
        ST_RALLY   = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    localparam int CLK_HZ        = 25_175_000;
    localparam int DEF_MAX_SCORE = 11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // True when one more point takes score_now to the winning score.
    function automatic logic is_win(input logic [3:0] score_now,
                                    input logic [3:0] max_score);
        return ((score_now + 4'd1) == max_score);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl_if
// Signal bundle between the match sequencer and its surroundings
// (start button, physics core, score/overlay renderer).
//   master : the sequencer   - consumes start_n / pt_p1 / pt_p2, drives the rest
//   slave  : the environment - drives start_n / pt_p1 / pt_p2, observes the rest
// -----------------------------------------------------------------------------
interface pong_match_ctrl_if;

    logic       start_n;
    logic       pt_p1;
    logic       pt_p2;
    logic       pos_reset;
    logic       ball_run;
    logic       ball_shown;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic       game_over;
    logic [2:0] state_dbg;

    modport master (
        input  start_n, pt_p1, pt_p2,
        output pos_reset, ball_run, ball_shown, serve_dir,
               score_p1, score_p2, winner, game_over, state_dbg
    );

    modport slave (
        output start_n, pt_p1, pt_p2,
        input  pos_reset, ball_run, ball_shown, serve_dir,
               score_p1, score_p2, winner, game_over, state_dbg
    );

endinterface

// File: rtl/pong_delay_timer.sv
// -----------------------------------------------------------------------------
// pong_delay_timer
// Loadable up-counter used for the serve delay and the game-over hold.
//   clk_0  : system clock
//   rst    : asynchronous active-high reset
//   clear  : count := 0 (wins over enable)
//   enable : count advances by one, saturating at limit
//   limit  : delay length in cycles for the phase being timed
//   done   : registered, high while the count equals limit-1
// -----------------------------------------------------------------------------
module pong_delay_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk_0,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;

    // Next count; done is computed from the next count so that the
    // registered flag lines up with the cycle in which count == limit-1.
    always_comb begin
        if (clear) begin
            cnt_d = ZERO;
        end else if (enable && (cnt_q != limit)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
        done_d = (cnt_d == (limit - ONE));
    end

    // Counter and done flag registers
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            cnt_q  <= ZERO;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
// Match-flow sequencer for the Pong console. Owns the game state, scores,
// serve delay and game-over hold; strobes the physics core to recentre and
// enables ball motion/visibility.
//   clk_0 : 25.175 MHz system clock
//   rst   : asynchronous active-high reset
//   bus   : pong_match_ctrl_if.master
//           in : start_n (active low, synchronised), pt_p1, pt_p2
//           out: pos_reset, ball_run, ball_shown, serve_dir, score_p1,
//                score_p2, winner, game_over, state_dbg
// -----------------------------------------------------------------------------
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_DELAY_CYC = 50_350_000,
    parameter int OVER_HOLD_CYC   = 125_875_000,
    parameter int MAX_SCORE       = DEF_MAX_SCORE,
    parameter int CNT_W           = 27
) (
    input  logic               clk_0,
    input  logic               rst,
    pong_match_ctrl_if.master  bus
);

    localparam logic [3:0]       MAX_S     = 4'(MAX_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LIM = CNT_W'(SERVE_DELAY_CYC);
    localparam logic [CNT_W-1:0] OVER_LIM  = CNT_W'(OVER_HOLD_CYC);

    state_e     state_d, state_q;
    logic       start_prev_d, start_prev_q;
    logic [3:0] score_p1_d, score_p1_q;
    logic [3:0] score_p2_d, score_p2_q;
    logic [1:0] winner_d, winner_q;
    logic       serve_dir_d, serve_dir_q;
    logic       pos_reset_d, pos_reset_q;
    logic       ball_run_d, ball_run_q;
    logic       ball_shown_d, ball_shown_q;
    logic       game_over_d, game_over_q;

    logic             press_s;
    logic             p1_win_s;
    logic             p2_win_s;
    logic             timer_clear_s;
    logic             timer_en_s;
    logic [CNT_W-1:0] timer_limit_s;
    logic             timer_done_s;

    // Start press = previous sample released, current sample pressed
    always_comb begin
        start_prev_d = bus.start_n;
        press_s      = start_prev_q & ~bus.start_n;
        p1_win_s     = is_win(score_p1_q, MAX_S);
        p2_win_s     = is_win(score_p2_q, MAX_S);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ATTRACT: begin
                if (press_s) state_d = ST_POINT;
                else         state_d = ST_ATTRACT;
            end
            ST_POINT: begin
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (timer_done_s) state_d = ST_RALLY;
                else              state_d = ST_SERVE;
            end
            ST_RALLY: begin
                // pt_p1 wins a same-cycle tie
                if (bus.pt_p1)      state_d = p1_win_s ? ST_OVER : ST_POINT;
                else if (bus.pt_p2) state_d = p2_win_s ? ST_OVER : ST_POINT;
                else                state_d = ST_RALLY;
            end
            ST_OVER: begin
                if (press_s)           state_d = ST_POINT;
                else if (timer_done_s) state_d = ST_ATTRACT;
                else                   state_d = ST_OVER;
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
    end

    // Delay timer control: restart on every state change so each timed
    // phase begins at zero, and pick the limit for the phase being entered.
    always_comb begin
        timer_clear_s = (state_d != state_q);
        timer_en_s    = (state_q == ST_SERVE) || (state_q == ST_OVER);
        if (state_d == ST_OVER) timer_limit_s = OVER_LIM;
        else                    timer_limit_s = SERVE_LIM;
    end

    // Scores, winner and serve direction
    always_comb begin
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        case (state_q)
            ST_ATTRACT, ST_OVER: begin
                if (press_s) begin
                    score_p1_d  = 4'd0;
                    score_p2_d  = 4'd0;
                    winner_d    = WIN_NONE;
                    serve_dir_d = 1'b0;
                end else begin
                    score_p1_d  = score_p1_q;
                end
            end
            ST_RALLY: begin
                if (bus.pt_p1) begin
                    score_p1_d  = score_p1_q + 4'd1;
                    serve_dir_d = 1'b1;
                    if (p1_win_s) winner_d = WIN_P1;
                    else          winner_d = winner_q;
                end else if (bus.pt_p2) begin
                    score_p2_d  = score_p2_q + 4'd1;
                    serve_dir_d = 1'b0;
                    if (p2_win_s) winner_d = WIN_P2;
                    else          winner_d = winner_q;
                end else begin
                    score_p1_d  = score_p1_q;
                end
            end
            default: begin
                score_p1_d = score_p1_q;
            end
        endcase
    end

    // Output decode from the next state, registered alongside the state
    always_comb begin
        pos_reset_d  = (state_d == ST_POINT);
        ball_run_d   = (state_d == ST_RALLY);
        ball_shown_d = (state_d == ST_RALLY);
        game_over_d  = (state_d == ST_OVER);
    end

    // State, match data and output registers
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ATTRACT;
            start_prev_q <= 1'b1;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            winner_q     <= WIN_NONE;
            serve_dir_q  <= 1'b0;
            pos_reset_q  <= 1'b0;
            ball_run_q   <= 1'b0;
            ball_shown_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            pos_reset_q  <= pos_reset_d;
            ball_run_q   <= ball_run_d;
            ball_shown_q <= ball_shown_d;
            game_over_q  <= game_over_d;
        end
    end

    pong_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_0  (clk_0),
        .rst    (rst),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .limit  (timer_limit_s),
        .done   (timer_done_s)
    );

    assign bus.pos_reset  = pos_reset_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.ball_shown = ball_shown_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score_p1   = score_p1_q;
    assign bus.score_p2   = score_p2_q;
    assign bus.winner     = winner_q;
    assign bus.game_over  = game_over_q;
    assign bus.state_dbg  = state_q;

endmodule
